// File: rtl/bus_rx_endpoint.sv
// Receive-side endpoint: filters broadcast bus beats on destination ID and
// buffers accepted beats in a first-word-fall-through FIFO for the local consumer.
module bus_rx_endpoint #(
    parameter int         pckg_sz = 16,
    parameter int         depth   = 8,
    parameter logic [7:0] id      = 8'd0,
    parameter logic [7:0] bdcst   = 8'hFF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [pckg_sz-1:0]         D_push,
    input  logic                       pop,
    output logic [pckg_sz-1:0]         D_pop,
    output logic                       pndng,
    output logic                       full,
    output logic [$clog2(depth):0]     count,
    output logic [7:0]                 ovf_cnt,
    output logic [7:0]                 mis_cnt
);

    localparam int AW = $clog2(depth);
    localparam int CW = AW + 1;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'hFF) begin
            r = v;
        end else begin
            r = v + 8'd1;
        end
        return r;
    endfunction

    logic [pckg_sz-1:0] mem_q [depth];
    logic [AW-1:0]      wptr_q, wptr_d;
    logic [AW-1:0]      rptr_q, rptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic [7:0]         ovf_cnt_q, ovf_cnt_d;
    logic [7:0]         mis_cnt_q, mis_cnt_d;

    logic [7:0]         dest_s;
    logic               hit_s;
    logic               full_s;
    logic               pndng_s;
    logic               wr_s;
    logic               rd_s;
    logic [pckg_sz-1:0] d_pop_s;

    // Match, handshake decode and next-state computation.
    always_comb begin
        dest_s    = D_push[pckg_sz-1 -: 8];
        hit_s     = push & ((dest_s == id) | (dest_s == bdcst));
        full_s    = (count_q == CW'(depth));
        pndng_s   = (count_q != {CW{1'b0}});
        wr_s      = hit_s & (~full_s | pop);
        rd_s      = pop & pndng_s;

        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        ovf_cnt_d = ovf_cnt_q;
        mis_cnt_d = mis_cnt_q;

        if (wr_s) begin
            wptr_d = wptr_q + {{(AW-1){1'b0}}, 1'b1};
        end else begin
            wptr_d = wptr_q;
        end

        if (rd_s) begin
            rptr_d = rptr_q + {{(AW-1){1'b0}}, 1'b1};
        end else begin
            rptr_d = rptr_q;
        end

        count_d = count_q + {{(CW-1){1'b0}}, wr_s} - {{(CW-1){1'b0}}, rd_s};

        // A dropped beat only counts as overflow when a pop did not free a slot.
        if (hit_s & full_s & ~pop) begin
            ovf_cnt_d = sat_inc(ovf_cnt_q);
        end else begin
            ovf_cnt_d = ovf_cnt_q;
        end

        if (push & ~hit_s) begin
            mis_cnt_d = sat_inc(mis_cnt_q);
        end else begin
            mis_cnt_d = mis_cnt_q;
        end
    end

    // Pointer, occupancy and statistics state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q    <= {AW{1'b0}};
            rptr_q    <= {AW{1'b0}};
            count_q   <= {CW{1'b0}};
            ovf_cnt_q <= 8'd0;
            mis_cnt_q <= 8'd0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            ovf_cnt_q <= ovf_cnt_d;
            mis_cnt_q <= mis_cnt_d;
        end
    end

    // Storage array; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_s) begin
            mem_q[wptr_q] <= D_push;
        end
    end

    // Head entry is read straight from registered storage, zeroed when empty.
    always_comb begin
        if (pndng_s) begin
            d_pop_s = mem_q[rptr_q];
        end else begin
            d_pop_s = {pckg_sz{1'b0}};
        end
    end

    assign D_pop   = d_pop_s;
    assign pndng   = pndng_s;
    assign full    = full_s;
    assign count   = count_q;
    assign ovf_cnt = ovf_cnt_q;
    assign mis_cnt = mis_cnt_q;

endmodule
